// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// instruction field positions decoded from IF/ID, and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load wins over flush, flush only drops the valid
// bit so the instruction and link value stay put until the next load.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc_plus1,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus1,
  output logic [5:0]             opcode,
  output logic [5:0]             funct
);

  logic                   vld_p1;
  logic [INSTR_WIDTH-1:0] instr_p1;
  logic [PC_WIDTH-1:0]    pc_plus1_p1;

  // Valid bit: set on load, cleared on flush or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end
  end

  // Instruction payload changes only when a new instruction is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1    <= '0;
      pc_plus1_p1 <= '0;
    end else if (load) begin
      instr_p1    <= load_instr;
      pc_plus1_p1 <= load_pc_plus1;
    end
  end

  assign if_id_valid    = vld_p1;
  assign if_id_instr    = instr_p1;
  assign if_id_pc_plus1 = pc_plus1_p1;
  assign opcode         = instr_p1[OPCODE_MSB:OPCODE_LSB];
  assign funct          = instr_p1[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-addressed requests to
// instruction memory, parks one response while decode is stalled, and drops
// responses belonging to requests made before a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus1,
  output logic [5:0]             opcode,
  output logic [5:0]             funct
);

  fetch_state_e           state;
  fetch_state_e           nxt_state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    nxt_pc;
  logic [PC_WIDTH-1:0]    pc_plus1;
  logic [PC_WIDTH-1:0]    req_addr;
  logic [INSTR_WIDTH-1:0] buf_instr;
  logic [PC_WIDTH-1:0]    buf_pc_plus1;
  logic                   buf_we;
  logic                   ifid_load;
  logic                   ifid_flush;
  logic [INSTR_WIDTH-1:0] ifid_instr_in;
  logic [PC_WIDTH-1:0]    ifid_pc_plus1_in;

  // Wraps modulo 2^PC_WIDTH with no carry out.
  assign pc_plus1 = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // No request while the buffer is occupied or while reset is asserted.
  assign imem_req  = !rst && (state != ST_HOLD);
  assign imem_addr = req_addr;

  // Next-state, PC and IF/ID control decode; redirect outranks everything.
  always_comb begin
    nxt_state        = state;
    nxt_pc           = pc;
    buf_we           = 1'b0;
    ifid_load        = 1'b0;
    ifid_flush       = 1'b0;
    ifid_instr_in    = imem_rdata;
    ifid_pc_plus1_in = pc_plus1;
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          nxt_pc     = redirect_target;
          nxt_state  = imem_valid ? ST_FETCH : ST_DISCARD;
        end else if (imem_valid) begin
          nxt_pc = pc_plus1;
          if (stall) begin
            buf_we    = 1'b1;
            nxt_state = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        ifid_instr_in    = buf_instr;
        ifid_pc_plus1_in = buf_pc_plus1;
        if (redirect) begin
          ifid_flush = 1'b1;
          nxt_pc     = redirect_target;
          nxt_state  = ST_FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          nxt_state = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          nxt_pc     = redirect_target;
        end else if (imem_valid) begin
          nxt_state = ST_FETCH;
        end
      end
      default: begin
        nxt_state = ST_FETCH;
      end
    endcase
  end

  // FSM, PC and request address; the address is frozen while a stale request drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= nxt_state;
      pc       <= nxt_pc;
      if (nxt_state != ST_DISCARD) begin
        req_addr <= nxt_pc;
      end
    end
  end

  // One-entry buffer for a response that arrives while decode is stalled.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_instr    <= imem_rdata;
      buf_pc_plus1 <= pc_plus1;
    end
  end

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (ifid_load),
    .flush          (ifid_flush),
    .load_instr     (ifid_instr_in),
    .load_pc_plus1  (ifid_pc_plus1_in),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .opcode         (opcode),
    .funct          (funct)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized stall/redirect/latency traffic against a
// queue-style reference of the fetch stream, plus directed corner cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_target;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc_plus1;
  logic [5:0]  opcode, funct;

  logic        w_stall, w_redirect;
  logic [31:0] w_target;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata;
  logic        w_if_valid;
  logic [31:0] w_if_instr, w_if_pp1;
  logic [5:0]  w_opcode, w_funct;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc_plus1(if_id_pc_plus1),
    .opcode(opcode), .funct(funct)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst(rst), .stall(w_stall), .redirect(w_redirect),
    .redirect_target(w_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(w_valid), .imem_rdata(w_rdata), .if_id_valid(w_if_valid),
    .if_id_instr(w_if_instr), .if_id_pc_plus1(w_if_pp1),
    .opcode(w_opcode), .funct(w_funct)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a << 4;
  endfunction

  // Reference: architectural PC, IF/ID contents, a one-slot side buffer and
  // a flag saying an abandoned request still owes a response.
  logic [31:0] m_pc, m_instr, m_pp1, m_buf_instr, m_buf_pp1;
  logic        m_valid, m_buf_full, m_drop;

  // Memory responder: one response per request after a random latency.
  logic        mbusy;
  int          mcnt, mlat, lat_min, lat_max;
  logic [31:0] maddr;

  task automatic model_edge(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = '0; m_pp1 = '0;
      m_buf_full = 1'b0; m_drop = 1'b0;
    end else if (rd) begin
      m_valid = 1'b0;
      m_pc    = tgt;
      if (m_buf_full) m_buf_full = 1'b0;
      else if (!m_drop) m_drop = !imem_valid;
    end else if (m_drop) begin
      if (imem_valid) m_drop = 1'b0;
    end else if (m_buf_full) begin
      if (!s) begin
        m_valid = 1'b1; m_instr = m_buf_instr; m_pp1 = m_buf_pp1; m_buf_full = 1'b0;
      end
    end else if (imem_valid) begin
      if (s) begin
        m_buf_full = 1'b1; m_buf_instr = imem_rdata; m_buf_pp1 = m_pc + 32'd1;
      end else begin
        m_valid = 1'b1; m_instr = imem_rdata; m_pp1 = m_pc + 32'd1;
      end
      m_pc = m_pc + 32'd1;
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
    check_eq("if_id_valid", if_id_valid, m_valid);
    check_eq("if_id_instr", if_id_instr, m_instr);
    check_eq("if_id_pc_plus1", if_id_pc_plus1, m_pp1);
    check_eq("opcode", opcode, m_instr[31:26]);
    check_eq("funct", funct, m_instr[5:0]);
    if (if_id_valid === 1'b1)
      check_eq("instr_vs_addr", if_id_instr, mem_word(if_id_pc_plus1 - 32'd1));
    rst = r; stall = s; redirect = rd; redirect_target = tgt;
    #1;
    check_eq("imem_req", imem_req, !r && !m_buf_full);
    if (!r && !m_buf_full && !m_drop) check_eq("imem_addr", imem_addr, m_pc);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (r) begin
      mbusy = 1'b0;
    end else if (imem_req) begin
      if (!mbusy) begin
        mbusy = 1'b1; maddr = imem_addr; mcnt = 0;
        mlat = $urandom_range(lat_max, lat_min);
      end else begin
        check_eq("addr_hold", imem_addr, maddr);
      end
      if (mcnt == mlat) begin
        imem_valid = 1'b1; imem_rdata = mem_word(maddr); mbusy = 1'b0;
      end else begin
        mcnt++;
      end
    end else if (mbusy) begin
      check_eq("req_held", imem_req, 1'b1);
    end
    w_valid = w_req;
    w_rdata = mem_word(w_addr);
    model_edge(r, s, rd, tgt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    w_stall = 1'b0; w_redirect = 1'b0; w_target = '0; w_valid = 1'b0; w_rdata = '0;
    mbusy = 1'b0; mcnt = 0; mlat = 0; maddr = '0; lat_min = 0; lat_max = 0;
    m_buf_instr = '0; m_buf_pp1 = '0;
    model_edge(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", if_id_valid, 1'b0);
    check_eq("rst_instr", if_id_instr, 32'h0);
    check_eq("rst_pp1", if_id_pc_plus1, 32'h0);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, 32'h0);

    // Zero-wait memory: one instruction per cycle from address 0.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        check_eq("first_valid", if_id_valid, 1'b0);
        check_eq("wrap_first_addr", w_addr, 32'hFFFF_FFFF);
      end else begin
        check_eq("seq_instr", if_id_instr, 32'((i - 1) * 16));
        check_eq("seq_pp1", if_id_pc_plus1, 32'(i));
      end
      if (i == 1) begin
        check_eq("wrap_instr", w_if_instr, 32'hFFFF_FFF0);
        check_eq("wrap_pp1", w_if_pp1, 32'h0);
        check_eq("wrap_next_addr", w_addr, 32'h0);
      end
      if (i == 2) begin
        check_eq("wrap_instr2", w_if_instr, 32'h0);
        check_eq("wrap_pp1_2", w_if_pp1, 32'h1);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end

    // Two wait states per fetch.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Stall on the response cycle, then redirect+stall while holding.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 6 && !m_buf_full; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("hold_reached", imem_req, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h80);
    check_eq("hold_redir_flush", if_id_valid, 1'b0);
    check_eq("hold_redir_req", imem_req, 1'b1);
    check_eq("hold_redir_addr", imem_addr, 32'h80);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect while a slow request is outstanding: its response is dropped.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && !(mbusy && mcnt == 1); i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 20 && if_id_valid !== 1'b1; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("discard_valid", if_id_valid, 1'b1);
    check_eq("discard_instr", if_id_instr, 32'h400);
    check_eq("discard_pp1", if_id_pc_plus1, 32'h41);

    // Random traffic.
    lat_min = 0; lat_max = 2;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      bit r, s, rd;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      step(r, s, rd, tgt);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
